// File: rtl/spi_sclk_gen.sv
// SPI serial-clock and frame generator: programmable half-period, selectable idle
// polarity, free-run or counted frames with chip-select setup/hold, edge strobes.
module spi_sclk_gen #(
    parameter int   DIV_W = 8,
    parameter int   CNT_W = 6,
    parameter logic CPOL  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] half_period,
    input  logic [CNT_W-1:0] num_bits,
    input  logic             free_run,
    input  logic             start,
    output logic             sclk,
    output logic             cs_n,
    output logic             lead_stb,
    output logic             trail_stb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W:0]   edge_q, edge_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             lead_q, lead_d;
    logic             trail_q, trail_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] h_live;
    logic             wrap_live;
    logic             wrap_frame;
    logic             at_idle_level;
    logic             toggle;

    assign h_live        = (half_period == '0) ? DIV_W'(1) : half_period;
    // >= rather than == so a live half_period shrink never strands the counter
    assign wrap_live     = (cnt_q >= (h_live - DIV_W'(1)));
    assign wrap_frame    = (cnt_q == (h_q - DIV_W'(1)));
    assign at_idle_level = (sclk_q == CPOL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        n_d     = n_q;
        edge_d  = edge_q;
        toggle  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!free_run && at_idle_level) begin
                    cnt_d = '0;
                    if (start && (num_bits != '0)) begin
                        state_d = SETUP;
                        h_d     = h_live;
                        n_d     = num_bits;
                        edge_d  = '0;
                    end
                end else if (wrap_live) begin
                    // Free-run, or finishing the half-period that returns sclk to idle
                    toggle = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            SETUP: begin
                if (wrap_frame) begin
                    toggle  = 1'b1;
                    cnt_d   = '0;
                    edge_d  = (CNT_W+1)'(1);
                    state_d = ACTIVE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ACTIVE: begin
                if (wrap_frame) begin
                    cnt_d = '0;
                    if (edge_q == {n_q, 1'b0}) begin
                        state_d = HOLD;
                    end else begin
                        toggle = 1'b1;
                        edge_d = edge_q + (CNT_W+1)'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (wrap_frame) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        sclk_d  = sclk_q ^ toggle;
        lead_d  = toggle & at_idle_level;
        trail_d = toggle & ~at_idle_level;
        cs_n_d  = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            n_q     <= '0;
            edge_q  <= '0;
            sclk_q  <= CPOL;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            n_q     <= n_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            lead_q  <= lead_d;
            trail_q <= trail_d;
            done_q  <= done_d;
        end
    end

    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign lead_stb  = lead_q;
    assign trail_stb = trail_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
